// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU data-bus grant arbiter.
// Optional build macro: ARB_TIMEOUT_EN (bounded hold time per owner).
package cpu_bus_pkg;

  localparam int N_SRC     = 32;
  localparam int SRC_IDX_W = 5;
  localparam int HOLD_MAX  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [SRC_IDX_W-1:0] onehot_to_idx(
    input logic [N_SRC-1:0] oh
  );
    logic [SRC_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (oh[i]) idx = idx | SRC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_grant_arbiter_if.sv
// Request/grant bundle between bus sources and the grant arbiter.
// Optional build macro: ARB_TIMEOUT_EN drives the timeout pulse.
interface bus_grant_arbiter_if;
  import cpu_bus_pkg::*;

  logic [N_SRC-1:0] req;
  logic             rel;
  logic [N_SRC-1:0] grant;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req,
    output rel,
    input  grant,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  rel,
    output grant,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/bus_grant_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotate, lowest-set-bit find, un-rotate.
// Unaffected by ARB_TIMEOUT_EN.
module rr_priority_pick
  import cpu_bus_pkg::*;
(
  input  logic [N_SRC-1:0]     req,
  input  logic [SRC_IDX_W-1:0] last_ptr,
  output logic [N_SRC-1:0]     win,
  output logic                 any
);

  logic [SRC_IDX_W-1:0] start;
  logic [N_SRC-1:0]     rot;
  logic [N_SRC-1:0]     fixed;

  assign start = last_ptr + SRC_IDX_W'(1);

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rot[i] = req[SRC_IDX_W'(i) + start];
    end
  end

  // isolate lowest set bit: rot bit 0 is the source just after last_ptr
  assign fixed = rot & (~rot + N_SRC'(1));

  always_comb begin
    win = '0;
    for (int i = 0; i < N_SRC; i++) begin
      win[SRC_IDX_W'(i) + start] = fixed[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin one-hot bus grant with a dead cycle between owners.
// Optional build macro: ARB_TIMEOUT_EN forces release after HOLD_MAX cycles.
module bus_grant_arbiter
  import cpu_bus_pkg::*;
(
  input logic          clk,
  input logic          clr,
  bus_grant_arbiter_if.slave bus
);

  state_t               state_q, state_d;
  logic [N_SRC-1:0]     grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic [SRC_IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [N_SRC-1:0]     win;
  logic                 any;
  logic                 hold_expire;
  logic                 release_now;

  rr_priority_pick u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr_q),
    .win      (win),
    .any      (any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;

  assign hold_expire = (cnt_q == 4'(HOLD_MAX - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == GRANT) cnt_d = cnt_q + 4'd1;
    if (state_d == GRANT && state_q != GRANT) cnt_d = '0;
  end
`else
  assign hold_expire = 1'b0;
`endif

  assign release_now = bus.rel
                     | ~|(bus.req & grant_q)
                     | hold_expire;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (any) begin
          state_d    = GRANT;
          grant_d    = win;
          last_ptr_d = onehot_to_idx(win);
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d   = GAP;
          grant_d   = '0;
          timeout_d = hold_expire;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      last_ptr_q <= SRC_IDX_W'(N_SRC - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;

  a_onehot: assert property (@(posedge clk) disable iff (clr)
    $onehot0(grant_q));
  a_valid: assert property (@(posedge clk) disable iff (clr)
    valid_q == (|grant_q));

endmodule
